// File: rtl/pmem_responder.sv
// Memory side of the pmem line-transfer protocol, backed by an on-chip line array.
// Latency: pmem_resp rises LATENCY edges after acceptance and stays high one cycle.
// Backpressure: one transfer at a time; requests seen in BUSY/RESP are ignored.
module pmem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         proto_err,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    localparam int         IDX_W    = $clog2(DEPTH_LINES);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [127:0]       wdata_q;
    logic               op_wr_q;
    logic               req;
    logic               accept;
    logic               abort;
    logic               commit;
    logic               unused_addr;

    logic [127:0] mem [DEPTH_LINES];

    assign req = pmem_read | pmem_write;

    // Offset bits and aliased upper bits carry no information here.
    assign unused_addr = ^pmem_address;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_wr_q    <= 1'b0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            pmem_resp <= commit;
            if (accept) begin
                idx_q   <= pmem_address[4 +: IDX_W];
                wdata_q <= pmem_wdata;
                op_wr_q <= pmem_write;
                cnt_q   <= CNT_LOAD;
                if (pmem_read && pmem_write) begin
                    proto_err <= 1'b1;
                end
            end else if (state_q == BUSY && !commit && !abort) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (commit) begin
                if (op_wr_q) begin
                    wr_count <= wr_count + 16'd1;
                end else begin
                    rd_count   <= rd_count + 16'd1;
                    pmem_rdata <= mem[idx_q];
                end
            end
        end
    end

    // Array is deliberately not reset; commit is never asserted during reset.
    always_ff @(posedge clk) begin
        if (commit && op_wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
